// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel/line position from 640x480 hsync/vsync and tracks lock
module vga_sync_receiver #(
    parameter int HT          = 800,
    parameter int HD          = 640,
    parameter int VT          = 525,
    parameter int VD          = 480,
    parameter int H_FALL_PIX  = 656,
    parameter int V_FALL_LINE = 489,
    parameter int V_FALL_PIX  = 1,
    parameter int H_GOOD      = 2
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] rx_h_cnt,
    output logic [9:0] rx_v_cnt,
    output logic       rx_valid,
    output logic       locked,
    output logic       frame_start,
    output logic       err,
    output logic [7:0] err_cnt
);
    typedef enum logic [1:0] {SEARCH, H_TRAIN, V_WAIT, LOCKED} state_t;

    localparam logic [9:0] H_LAST = 10'(HT - 1);
    localparam logic [9:0] V_LAST = 10'(VT - 1);
    localparam logic [9:0] H_FALL = 10'(H_FALL_PIX);
    localparam logic [9:0] V_FALL = 10'(V_FALL_LINE);
    localparam logic [9:0] V_PIX  = 10'(V_FALL_PIX);
    localparam logic [9:0] H_ACT  = 10'(HD);
    localparam logic [9:0] V_ACT  = 10'(VD);
    localparam logic [7:0] GOOD_N = 8'(H_GOOD);

    state_t     state, state_nx;
    logic       hs_q, vs_q, hs_fall, vs_fall, h_at, v_at, err_now;
    logic [9:0] hpos, vpos;
    logic [7:0] good, good_nx;

    assign hs_fall = hs_q & ~hsync;
    assign vs_fall = vs_q & ~vsync;
    assign h_at    = hpos == H_FALL;
    assign v_at    = vpos == V_FALL && hpos == V_PIX;

    // next state and error detection; any error drops back to SEARCH
    always_comb begin
        state_nx = state;
        good_nx  = good;
        err_now  = 1'b0;
        case (state)
            SEARCH: begin
                if (hs_fall) begin
                    state_nx = H_TRAIN;
                    good_nx  = '0;
                end
            end
            H_TRAIN: begin
                err_now = h_at & ~hs_fall;
                if (hs_fall && h_at) begin
                    good_nx = good + 8'd1;
                    if (good_nx >= GOOD_N) state_nx = V_WAIT;
                end else if (hs_fall) begin
                    good_nx = '0;
                end
            end
            V_WAIT: begin
                err_now = (hs_fall ^ h_at) | (vs_fall & (hpos != V_PIX));
                if (vs_fall) state_nx = LOCKED;
            end
            LOCKED: err_now = (hs_fall ^ h_at) | (vs_fall ^ v_at);
            default: ;
        endcase
        if (err_now) state_nx = SEARCH;
    end

    // state, position counters, sync history and error bookkeeping
    always_ff @(posedge pclk) begin
        if (reset) begin
            state   <= SEARCH;
            good    <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            hpos    <= '0;
            vpos    <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_nx;
            good  <= good_nx;
            hs_q  <= hsync;
            vs_q  <= vsync;
            hpos  <= (hs_fall && (state == SEARCH || (state == H_TRAIN && !h_at))) ? H_FALL + 10'd1 :
                     (hpos == H_LAST ? '0 : hpos + 10'd1);
            if (state != LOCKED && state_nx == LOCKED) vpos <= V_FALL;
            else if (state == LOCKED && hpos == H_LAST) vpos <= vpos == V_LAST ? '0 : vpos + 10'd1;
            err <= err_now;
            if (err_now && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign locked      = state == LOCKED;
    assign rx_valid    = locked && hpos < H_ACT && vpos < V_ACT;
    assign rx_h_cnt    = rx_valid ? hpos : '0;
    assign rx_v_cnt    = rx_valid ? vpos : '0;
    assign frame_start = locked && hpos == '0 && vpos == '0;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: scoreboard bench driving a scaled sync source with scheduled faults
module tb_vga_sync_receiver;
    localparam int HT = 48, HD = 32, VT = 20, VD = 16;
    localparam int HF = 36, VFL = 17, VFP = 1, HG = 2, HW = 4;

    logic       pclk = 1'b0, reset = 1'b1, hsync = 1'b1, vsync = 1'b1;
    logic [9:0] rx_h_cnt, rx_v_cnt;
    logic       rx_valid, locked, frame_start, err;
    logic [7:0] err_cnt;

    vga_sync_receiver #(
        .HT(HT), .HD(HD), .VT(VT), .VD(VD), .H_FALL_PIX(HF),
        .V_FALL_LINE(VFL), .V_FALL_PIX(VFP), .H_GOOD(HG)
    ) dut (
        .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .rx_h_cnt(rx_h_cnt), .rx_v_cnt(rx_v_cnt), .rx_valid(rx_valid),
        .locked(locked), .frame_start(frame_start), .err(err), .err_cnt(err_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] e;
        int          fr, v, h;
    } item_t;

    item_t sbq[$];
    int    errors = 0, checks = 0;
    int    sh = 0, sv = 0, fr = 0, cnt = 0, vcnt = 0, fcnt = 0, ecnt = 0;
    bit    lk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(bit l, bit va, bit f, bit e, int h, int v, int c);
        return {l, va, f, e, 10'(h), 10'(v), 8'(c)};
    endfunction

    function automatic bit skip_fr(int f);
        return f >= 4 && f <= 30;
    endfunction

    // scheduled fault points: the receiver must flag the pixel after the missing hsync edge
    function automatic bit err_pt();
        return sh == HF + 1 && (((fr == 2 || fr == 3) && sv == 5) || (skip_fr(fr) && sv % 2 == 1));
    endfunction

    // scheduled lock points: vsync fall at (VFL,VFP) after training, lock visible one pixel later
    function automatic bit lock_pt();
        return (fr == 0 || fr == 2 || fr == 3 || fr == 31 || fr == 33) && sv == VFL && sh == VFP + 1;
    endfunction

    task automatic cycle();
        int  d, lin;
        bit  miss, va, rst;
        item_t it;
        @(posedge pclk);
        #1;
        rst   = fr == 32 && sv == 5 && sh == 10;
        reset = rst;
        d     = (fr == 3 && sv == 5) ? 3 : 0;
        miss  = (fr == 2 && sv == 5) || (skip_fr(fr) && sv % 2 == 1);
        hsync = miss || !(sh >= HF + d && sh < HF + d + HW);
        lin   = sv * HT + sh;
        vsync = !(lin >= VFL * HT + VFP && lin < (VFL + 2) * HT + VFP);
        if (err_pt()) begin
            lk  = 1'b0;
            cnt = cnt < 255 ? cnt + 1 : 255;
        end
        if (lock_pt()) lk = 1'b1;
        va   = lk && sh < HD && sv < VD;
        it.e = pack(lk, va, lk && sh == 0 && sv == 0, err_pt(), va ? sh : 0, va ? sv : 0, cnt);
        it.fr = fr;
        it.v  = sv;
        it.h  = sh;
        sbq.push_back(it);
        if (rst) begin
            sh  = 0;
            sv  = 0;
            fr++;
            lk  = 1'b0;
            cnt = 0;
        end else if (sh == HT - 1) begin
            sh = 0;
            if (sv == VT - 1) begin
                sv = 0;
                fr++;
            end else sv++;
        end else sh++;
    endtask

    always @(negedge pclk) begin
        item_t it;
        if (sbq.size() > 0) begin
            it = sbq.pop_front();
            check($sformatf("out@%0d/%0d/%0d", it.fr, it.v, it.h),
                  {locked, rx_valid, frame_start, err, rx_h_cnt, rx_v_cnt, err_cnt}, it.e);
            if (it.fr == 1) begin
                vcnt += int'(rx_valid);
                fcnt += int'(frame_start);
            end
            ecnt += int'(err);
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("reset", {locked, rx_valid, frame_start, err, rx_h_cnt, rx_v_cnt, err_cnt}, 32'h0);
        while (fr < 2) cycle();
        @(negedge pclk);
        #1;
        check("valid_cnt", 32'(vcnt), 32'(HD * VD));
        check("fs_cnt", 32'(fcnt), 32'd1);
        check("err_cnt_clean", {24'h0, err_cnt}, 32'd0);
        while (fr < 4) cycle();
        @(negedge pclk);
        #1;
        check("err_cnt_two", {24'h0, err_cnt}, 32'd2);
        while (fr < 31) cycle();
        @(negedge pclk);
        #1;
        check("err_cnt_sat", {24'h0, err_cnt}, 32'd255);
        check("err_pulses", 32'(ecnt), 32'd272);
        while (fr < 35) cycle();
        @(negedge pclk);
        #1;
        check("final_locked", {31'h0, locked}, 32'd1);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
